pipe_arbiter: RTL and testbench



---
 rtl/pipe_arbiter_if.sv | 34 +++
 rtl/pipe_arbiter.sv | 115 +++++++++++
 tb/tb_pipe_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_arbiter_if.sv
// pipe_arbiter_if: bundles the two request ports, the shared datapath operand/result
// signals and the response port of pipe_arbiter.
// Modports: slave = arbiter view (takes requests, drives datapath + responses),
//           master = environment view (requesters, datapath, consumers).
interface pipe_arbiter_if #(
  parameter int N = 10
);
  logic           req0_valid;
  logic           req0_ready;
  logic [4*N-1:0] req0_data;
  logic           req1_valid;
  logic           req1_ready;
  logic [4*N-1:0] req1_data;
  logic [N-1:0]   pipe_a;
  logic [N-1:0]   pipe_b;
  logic [N-1:0]   pipe_c;
  logic [N-1:0]   pipe_d;
  logic [N-1:0]   pipe_y;
  logic           rsp0_valid;
  logic           rsp1_valid;
  logic [N-1:0]   rsp_data;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, pipe_y,
    output req0_ready, req1_ready, pipe_a, pipe_b, pipe_c, pipe_d,
           rsp0_valid, rsp1_valid, rsp_data
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, pipe_y,
    input  req0_ready, req1_ready, pipe_a, pipe_b, pipe_c, pipe_d,
           rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/pipe_arbiter.sv
// pipe_arbiter: round-robin share of one fixed-latency 4-operand datapath between two
// requesters; result returned to its owner LAT+1 cycles after the handshake edge.
// Backpressure: req*_ready drops when a requester has MAX_OUT results in flight; responses
// cannot be stalled.
// Ports: clk, rst_n (async active-low), bus (pipe_arbiter_if.slave).
// Optional: define PIPE_ARB_STATS_EN to add grant_cnt0/grant_cnt1 (16-bit, wrapping).
module pipe_arbiter #(
  parameter int N       = 10,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_arbiter_if.slave       bus
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`endif
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] out_cnt0, out_cnt1;
  logic          rr_pref1;   // 1: requester 1 wins a tie next
  logic          elig0, elig1;
  logic          grant0, grant1;
  logic          hs0, hs1, hs_any;

  // Tag pipe: bit 0 is loaded on the handshake edge together with the operand
  // registers, so one entry beyond LAT covers the operand register stage and the
  // last entry lines up with the edge at which pipe_y carries the matching result.
  logic [LAT:0]  tag_vld;
  logic [LAT:0]  tag_id;

  always_comb begin
    elig0  = bus.req0_valid && (out_cnt0 < CW'(MAX_OUT));
    elig1  = bus.req1_valid && (out_cnt1 < CW'(MAX_OUT));
    grant0 = elig0 && (!elig1 || !rr_pref1);
    grant1 = elig1 && (!elig0 ||  rr_pref1);
  end

  // Ready is gated by reset so every output reads 0 while rst_n is low.
  assign bus.req0_ready = grant0 && rst_n;
  assign bus.req1_ready = grant1 && rst_n;
  assign hs0    = bus.req0_valid && bus.req0_ready;
  assign hs1    = bus.req1_valid && bus.req1_ready;
  assign hs_any = hs0 || hs1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pipe_a     <= '0;
      bus.pipe_b     <= '0;
      bus.pipe_c     <= '0;
      bus.pipe_d     <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_data   <= '0;
      tag_vld        <= '0;
      tag_id         <= '0;
      rr_pref1       <= 1'b0;
      out_cnt0       <= '0;
      out_cnt1       <= '0;
    end else begin
      if (hs_any) begin
        if (hs1) begin
          bus.pipe_a <= bus.req1_data[4*N-1:3*N];
          bus.pipe_b <= bus.req1_data[3*N-1:2*N];
          bus.pipe_c <= bus.req1_data[2*N-1:N];
          bus.pipe_d <= bus.req1_data[N-1:0];
        end else begin
          bus.pipe_a <= bus.req0_data[4*N-1:3*N];
          bus.pipe_b <= bus.req0_data[3*N-1:2*N];
          bus.pipe_c <= bus.req0_data[2*N-1:N];
          bus.pipe_d <= bus.req0_data[N-1:0];
        end
        rr_pref1 <= hs0;
      end

      // Datapath never stalls, so tags advance every cycle.
      tag_vld <= {tag_vld[LAT-1:0], hs_any};
      tag_id  <= {tag_id[LAT-1:0], hs1};

      bus.rsp0_valid <= tag_vld[LAT] && !tag_id[LAT];
      bus.rsp1_valid <= tag_vld[LAT] &&  tag_id[LAT];
      if (tag_vld[LAT]) begin
        bus.rsp_data <= bus.pipe_y;
      end

      // A result counts as outstanding until its response pulse has been seen.
      case ({hs0, bus.rsp0_valid})
        2'b10:   out_cnt0 <= out_cnt0 + CW'(1);
        2'b01:   out_cnt0 <= out_cnt0 - CW'(1);
        default: out_cnt0 <= out_cnt0;
      endcase
      case ({hs1, bus.rsp1_valid})
        2'b10:   out_cnt1 <= out_cnt1 + CW'(1);
        2'b01:   out_cnt1 <= out_cnt1 - CW'(1);
        default: out_cnt1 <= out_cnt1;
      endcase
    end
  end

`ifdef PIPE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (hs0) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (hs1) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter: directed bench for pipe_arbiter with a 3-stage Y=A+B+C+D datapath
// model; every expected value is hand-computed for N=10, LAT=3, MAX_OUT=4.
module tb_pipe_arbiter;
  localparam int N   = 10;
  localparam int LAT = 3;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pipe_arbiter_if #(.N(N)) bus ();

`ifdef PIPE_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
  pipe_arbiter #(.N(N), .LAT(LAT), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
`else
  pipe_arbiter #(.N(N), .LAT(LAT), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  // Datapath: three register stages, result on pipe_y LAT cycles after operands.
  logic [N-1:0] s1 = '0;
  logic [N-1:0] s2 = '0;
  logic [N-1:0] s3 = '0;
  always @(posedge clk) begin
    s1 <= bus.pipe_a + bus.pipe_b + bus.pipe_c + bus.pipe_d;
    s2 <= s1;
    s3 <= s2;
  end
  assign bus.pipe_y = s3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle expectations for the limit/sharing run, bit c = cycle c.
  logic [17:0] exp_r0, exp_r1, exp_s0, exp_s1;

  initial begin
    exp_r0 = 18'b000001001111001111;
    exp_r1 = 18'b000000110000000000;
    exp_s0 = 18'b100111100111100000;
    exp_s1 = 18'b011000000000000000;

    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;

    // Reset state
    #12;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_pipe_a", bus.pipe_a, 0);
    chk("rst_pipe_d", bus.pipe_d, 0);
    chk("rst_rsp0", bus.rsp0_valid, 0);
    chk("rst_rsp1", bus.rsp1_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single issue from requester 0
    bus.req0_valid = 1'b1;
    bus.req0_data  = {10'd5, 10'd10, 10'd15, 10'd20};
    #1;
    chk("single_ready0", bus.req0_ready, 1);
    chk("single_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    chk("single_pipe_a", bus.pipe_a, 5);
    chk("single_pipe_b", bus.pipe_b, 10);
    chk("single_pipe_c", bus.pipe_c, 15);
    chk("single_pipe_d", bus.pipe_d, 20);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("single_rsp0", bus.rsp0_valid, (i == 4) ? 1 : 0);
      chk("single_rsp1", bus.rsp1_valid, 0);
      if (i >= 4) chk("single_rsp_data", bus.rsp_data, 50);
    end

    // Contention: pointer now prefers requester 1, so grants go 1,0,1,0
    bus.req0_valid = 1'b1;
    bus.req0_data  = {10'd4, 10'd8, 10'd12, 10'd16};
    bus.req1_valid = 1'b1;
    bus.req1_data  = {10'd3, 10'd6, 10'd9, 10'd12};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ready1", bus.req1_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_ready0", bus.req0_ready, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_rsp1", bus.rsp1_valid, (i % 2 == 0) ? 1 : 0);
      chk("cont_rsp0", bus.rsp0_valid, (i % 2 == 1) ? 1 : 0);
      chk("cont_rsp_data", bus.rsp_data, (i % 2 == 0) ? 30 : 40);
    end
    tick();
    chk("cont_idle_rsp0", bus.rsp0_valid, 0);
    chk("cont_idle_rsp1", bus.rsp1_valid, 0);
    tick();

    // Outstanding limit on requester 0, then requester 1 shares while 0 is blocked
    bus.req0_data = {10'd1, 10'd2, 10'd3, 10'd4};
    bus.req1_data = {10'd2, 10'd2, 10'd2, 10'd2};
    for (int c = 0; c < 18; c++) begin
      bus.req0_valid = (c <= 12);
      bus.req1_valid = (c >= 10 && c <= 12);
      #1;
      chk("lim_ready0", bus.req0_ready, exp_r0[c]);
      chk("lim_ready1", bus.req1_ready, exp_r1[c]);
      chk("lim_rsp0", bus.rsp0_valid, exp_s0[c]);
      chk("lim_rsp1", bus.rsp1_valid, exp_s1[c]);
      if (exp_s0[c]) chk("lim_rsp_data0", bus.rsp_data, 10);
      if (exp_s1[c]) chk("lim_rsp_data1", bus.rsp_data, 8);
      tick();
    end
`ifdef PIPE_ARB_STATS_EN
    chk("stats_cnt0", grant_cnt0, 12);
    chk("stats_cnt1", grant_cnt1, 4);
`endif

    // Reset mid-flight: three ops issued, reset asserted between edges
    bus.req0_valid = 1'b1;
    bus.req0_data  = {10'd7, 10'd7, 10'd7, 10'd7};
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready0", bus.req0_ready, 0);
    chk("mid_rst_pipe_a", bus.pipe_a, 0);
    chk("mid_rst_rsp0", bus.rsp0_valid, 0);
    chk("mid_rst_rsp1", bus.rsp1_valid, 0);
    chk("mid_rst_rsp_data", bus.rsp_data, 0);
`ifdef PIPE_ARB_STATS_EN
    chk("mid_rst_cnt0", grant_cnt0, 0);
`endif
    bus.req0_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_rsp0", bus.rsp0_valid, 0);
      chk("post_rst_rsp1", bus.rsp1_valid, 0);
    end
    bus.req0_valid = 1'b1;
    bus.req0_data  = {10'd9, 10'd1, 10'd1, 10'd1};
    bus.req1_valid = 1'b1;
    bus.req1_data  = {10'd6, 10'd1, 10'd1, 10'd1};
    #1;
    chk("post_rst_ready0", bus.req0_ready, 1);
    chk("post_rst_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("post_rst_pipe_a", bus.pipe_a, 9);
`ifdef PIPE_ARB_STATS_EN
    chk("post_rst_cnt0", grant_cnt0, 1);
    chk("post_rst_cnt1", grant_cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
